wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the packed MEM/WB writeback bus and the SIMD/AES unit's result stream.
- Pipeline writeback has priority. SIMD results are buffered in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so buffered SIMD results always drain.
- Sits between the MEM/WB stage and the register file.

Parameters:
- FIFO_DEPTH, 4, SIMD result buffer entries; power of 2, at least 2.
- STARVE_MAX, 8, consecutive non-granted cycles with a non-empty FIFO before a forced drain; range 1..255.
- DATA_W, 16, register-file data width.
- ADDR_W, 4, register-file address width.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- mem_wb_in  in  34  packed MEM/WB bus: [33] mem_rd, [32] writeBack, [31:28] destin, [27:12] result_alu, [11:0] dato.
- simd_valid  in  1  SIMD result valid.
- simd_dest  in  ADDR_W  SIMD destination register.
- simd_data  in  DATA_W  SIMD result.
- simd_ready  out  1  FIFO can accept; equals (count != FIFO_DEPTH), combinational.
- stall_pipe  out  1  registered; pipeline must hold mem_wb_in stable this cycle.
- rf_we  out  1  register-file write enable, registered.
- rf_addr  out  ADDR_W  write address, registered.
- rf_wdata  out  DATA_W  write data, registered.

Behaviour:
- Reset (async, reset_n=0):
  - rf_we=0, rf_addr=0, rf_wdata=0, stall_pipe=0.
  - FIFO empty, starve_cnt=0, state NORMAL, simd_ready=1.
  - Reset mid-operation discards buffered SIMD entries.
- Pipeline request:
  - pipe_req = mem_wb_in[32].
  - pipe_data = mem_wb_in[33] ? zero-extended dato : result_alu.
  - pipe_addr = mem_wb_in[31:28].
- SIMD push: on posedge when simd_valid & simd_ready. No push-through when full; pushing while full is ignored and the data is lost.
- FSM, two states:
  - NORMAL, grant selection:
    - pipe_req=1: grant pipeline.
    - otherwise, FIFO non-empty: grant FIFO head (pop).
    - otherwise: no grant, rf_we=0 next cycle.
  - NORMAL, starvation:
    - starve_cnt increments each posedge where FIFO is non-empty and not granted. It clears when the FIFO is granted or empty.
    - When starve_cnt reaches STARVE_MAX, next state is FORCE and stall_pipe becomes 1.
  - FORCE, exactly one cycle:
    - Grant FIFO head and ignore pipe_req; the pipeline holds.
    - Clear starve_cnt and return to NORMAL; stall_pipe returns to 0.
- Latency:
  - Granted write appears on rf_* one posedge after grant.
  - SIMD entry pushed at edge k reaches rf_* at edge k+1 at the earliest.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- Pointer wrap: modulo FIFO_DEPTH.
- Ordering:
  - Write order equals grant order. No destination-conflict checking is done.
  - Issue logic guarantees SIMD and pipeline destinations do not overlap while entries are pending.

Optional Feature:
- WB_STATS_EN.
- Defined: adds outputs stat_pipe_wr, stat_simd_wr and stat_stall_cyc, each 16 bits. They are saturating counters of granted pipeline writes, granted FIFO writes and FORCE cycles. All reset to 0 and stop at 0xFFFF.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package wb_arb_pkg holds:
  - Bus field offsets: MEM_RD_BIT=33, WB_BIT=32, DEST_HI/LO=31/28, ALU_HI/LO=27/12, DATO_HI/LO=11/0.
  - The 34-bit bus width constant.
  - The state enum {NORMAL, FORCE}.
- Sub-module wb_fifo: parameterized synchronous FIFO with push, pop, full, empty and count, storing {dest, data}.

Test Plan:
- ALU writeback: mem_wb_in={0,1,4'h3,16'hBEEF,12'h000} -> next posedge rf_we=1, rf_addr=3, rf_wdata=0xBEEF.
- Load writeback: mem_wb_in={1,1,4'h5,16'h1234,12'hABC} -> rf_wdata=0x0ABC, rf_addr=5.
- Idle SIMD drain: writeBack=0; push dest=7, data=0x55AA at edge k -> rf_we=1, rf_addr=7, rf_wdata=0x55AA after edge k+1; simd_ready stays 1.
- Starvation: writeBack=1 continuously; push one SIMD entry -> after 8 non-granted cycles stall_pipe=1 for exactly one cycle, the SIMD entry is written, then pipeline writes resume.
- Full FIFO: writeBack=1, STARVE_MAX set high (255); push 4 entries -> simd_ready=0; a fifth simd_valid is not accepted. After the pipeline idles, the four entries drain in FIFO order.
- Reset mid-operation: 3 entries buffered and rf_we=1; assert reset_n=0 asynchronously -> rf_*=0 and stall_pipe=0 immediately, simd_ready=1; after release no stale writes occur.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants, MEM/WB bus field offsets and the arbiter state type
// for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int MEM_WB_W   = 34;
    localparam int MEM_RD_BIT = 33;
    localparam int WB_BIT     = 32;
    localparam int DEST_HI    = 31;
    localparam int DEST_LO    = 28;
    localparam int ALU_HI     = 27;
    localparam int ALU_LO     = 12;
    localparam int DATO_HI    = 11;
    localparam int DATO_LO    = 0;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering {dest, data} SIMD results for the write-port arbiter.
// Pushes while full and pops while empty are ignored.
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; left unreset so stale contents are simply unreachable.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy tracking; power-of-2 depth makes wrap free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB writeback has priority, SIMD results
// are buffered and force a one-cycle pipeline stall when starved. Option: WB_STATS_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [MEM_WB_W-1:0] mem_wb_in,
    input  logic                simd_valid,
    input  logic [ADDR_W-1:0]   simd_dest,
    input  logic [DATA_W-1:0]   simd_data,
    output logic                simd_ready,
    output logic                stall_pipe,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]   rf_wdata
`ifdef WB_STATS_EN
    ,
    output logic [15:0]         stat_pipe_wr,
    output logic [15:0]         stat_simd_wr,
    output logic [15:0]         stat_stall_cyc
`endif
);

    localparam int         CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_e               state_r;
    logic [7:0]               starve_cnt_r;
    logic                     pipe_req_s;
    logic [ADDR_W-1:0]        pipe_addr_s;
    logic [DATA_W-1:0]        pipe_data_s;
    logic                     grant_pipe_s;
    logic                     grant_fifo_s;
    logic                     fifo_push_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [CNT_W-1:0]         fifo_count_s;
    logic [ADDR_W+DATA_W-1:0] fifo_head_s;

    assign pipe_req_s  = mem_wb_in[WB_BIT];
    assign pipe_addr_s = ADDR_W'(mem_wb_in[DEST_HI:DEST_LO]);
    assign pipe_data_s = mem_wb_in[MEM_RD_BIT] ? DATA_W'(mem_wb_in[DATO_HI:DATO_LO])
                                               : DATA_W'(mem_wb_in[ALU_HI:ALU_LO]);
    assign simd_ready  = (fifo_count_s != CNT_W'(FIFO_DEPTH));
    assign fifo_push_s = simd_valid & ~fifo_full_s;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push_s),
        .pop     (grant_fifo_s),
        .wr_data ({simd_dest, simd_data}),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Grant selection: FORCE ignores the pipeline so a starved entry drains.
    always_comb begin
        grant_pipe_s = 1'b0;
        grant_fifo_s = 1'b0;
        case (state_r)
            NORMAL: begin
                if (pipe_req_s) begin
                    grant_pipe_s = 1'b1;
                end else if (!fifo_empty_s) begin
                    grant_fifo_s = 1'b1;
                end else begin
                    grant_fifo_s = 1'b0;
                end
            end
            FORCE: begin
                if (!fifo_empty_s) begin
                    grant_fifo_s = 1'b1;
                end else begin
                    grant_fifo_s = 1'b0;
                end
            end
            default: begin
                grant_pipe_s = 1'b0;
                grant_fifo_s = 1'b0;
            end
        endcase
    end

    // Arbiter FSM with registered write port, stall and starvation counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= NORMAL;
            starve_cnt_r <= 8'd0;
            stall_pipe   <= 1'b0;
            rf_we        <= 1'b0;
            rf_addr      <= {ADDR_W{1'b0}};
            rf_wdata     <= {DATA_W{1'b0}};
        end else begin
            rf_we <= grant_pipe_s | grant_fifo_s;
            if (grant_pipe_s) begin
                rf_addr  <= pipe_addr_s;
                rf_wdata <= pipe_data_s;
            end else if (grant_fifo_s) begin
                rf_addr  <= fifo_head_s[ADDR_W+DATA_W-1:DATA_W];
                rf_wdata <= fifo_head_s[DATA_W-1:0];
            end else begin
                rf_addr  <= rf_addr;
                rf_wdata <= rf_wdata;
            end
            case (state_r)
                NORMAL: begin
                    if (fifo_empty_s || grant_fifo_s) begin
                        starve_cnt_r <= 8'd0;
                        stall_pipe   <= 1'b0;
                    end else if (starve_cnt_r == STARVE_LIM - 8'd1) begin
                        starve_cnt_r <= STARVE_LIM;
                        state_r      <= FORCE;
                        stall_pipe   <= 1'b1;
                    end else begin
                        starve_cnt_r <= starve_cnt_r + 8'd1;
                        stall_pipe   <= 1'b0;
                    end
                end
                FORCE: begin
                    starve_cnt_r <= 8'd0;
                    state_r      <= NORMAL;
                    stall_pipe   <= 1'b0;
                end
                default: begin
                    starve_cnt_r <= 8'd0;
                    state_r      <= NORMAL;
                    stall_pipe   <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_STATS_EN
    // Saturating activity counters for granted writes and forced-drain cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_pipe_wr   <= 16'd0;
            stat_simd_wr   <= 16'd0;
            stat_stall_cyc <= 16'd0;
        end else begin
            stat_pipe_wr   <= grant_pipe_s ? sat_inc16(stat_pipe_wr) : stat_pipe_wr;
            stat_simd_wr   <= grant_fifo_s ? sat_inc16(stat_simd_wr) : stat_simd_wr;
            stat_stall_cyc <= (state_r == FORCE) ? sat_inc16(stat_stall_cyc) : stat_stall_cyc;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed stimulus queues expected
// register-file writes, a negedge monitor pops and compares them.
module tb_wb_port_arbiter;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [33:0] mem_wb_in = 34'd0;
    logic        simd_valid = 1'b0;
    logic [3:0]  simd_dest = 4'd0;
    logic [15:0] simd_data = 16'd0;
    logic        simd_ready;
    logic        stall_pipe;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] rf_wdata;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    wb_port_arbiter #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (8),
        .DATA_W     (16),
        .ADDR_W     (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mem_wb_in  (mem_wb_in),
        .simd_valid (simd_valid),
        .simd_dest  (simd_dest),
        .simd_data  (simd_data),
        .simd_ready (simd_ready),
        .stall_pipe (stall_pipe),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clock = ~clock;

    function automatic logic [33:0] bus(input logic mr, input logic wb, input logic [3:0] d,
                                        input logic [15:0] alu, input logic [11:0] dato);
        return {mr, wb, d, alu, dato};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write-enable cycle must match the head of the scoreboard.
    always @(negedge clock) begin
        wr_t e;
        if (reset_n && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         rf_addr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {28'd0, rf_addr}, {28'd0, e.addr});
                check("wr_data", {16'd0, rf_wdata}, {16'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        logic [33:0] p;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_rf_addr", {28'd0, rf_addr}, 32'd0);
        check("rst_rf_wdata", {16'd0, rf_wdata}, 32'd0);
        check("rst_stall", {31'd0, stall_pipe}, 32'd0);
        check("rst_simd_ready", {31'd0, simd_ready}, 32'd1);
        reset_n = 1'b1;
        step();

        // ALU writeback
        mem_wb_in = bus(1'b0, 1'b1, 4'h3, 16'hBEEF, 12'h000);
        expect_wr(4'h3, 16'hBEEF);
        step();
        // Load writeback: dato zero-extended
        mem_wb_in = bus(1'b1, 1'b1, 4'h5, 16'h1234, 12'hABC);
        expect_wr(4'h5, 16'h0ABC);
        step();
        mem_wb_in = 34'd0;
        step();

        // Idle SIMD drain
        simd_valid = 1'b1;
        simd_dest  = 4'h7;
        simd_data  = 16'h55AA;
        expect_wr(4'h7, 16'h55AA);
        step();
        simd_valid = 1'b0;
        check("drain_simd_ready", {31'd0, simd_ready}, 32'd1);
        step();
        step();

        // Starvation: continuous writeback with one pending SIMD entry
        p = bus(1'b0, 1'b1, 4'h2, 16'h1111, 12'h000);
        mem_wb_in  = p;
        simd_valid = 1'b1;
        simd_dest  = 4'h9;
        simd_data  = 16'h9999;
        expect_wr(4'h2, 16'h1111);
        step();
        simd_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            expect_wr(4'h2, 16'h1111);
            step();
        end
        check("starve_no_stall_yet", {31'd0, stall_pipe}, 32'd0);
        expect_wr(4'h2, 16'h1111);
        step();
        check("starve_stall_on", {31'd0, stall_pipe}, 32'd1);
        expect_wr(4'h9, 16'h9999);
        step();
        check("starve_stall_off", {31'd0, stall_pipe}, 32'd0);
        expect_wr(4'h2, 16'h1111);
        step();
        expect_wr(4'h2, 16'h1111);
        step();
        mem_wb_in = 34'd0;
        step();

        // Full FIFO: four entries behind pipeline writes, fifth dropped
        mem_wb_in  = bus(1'b0, 1'b1, 4'h1, 16'h2222, 12'h000);
        simd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            simd_dest = 4'hA + 4'(i);
            simd_data = 16'hA0A0 + 16'(i);
            expect_wr(4'h1, 16'h2222);
            step();
        end
        check("full_not_ready", {31'd0, simd_ready}, 32'd0);
        simd_dest = 4'hE;
        simd_data = 16'hDEAD;
        expect_wr(4'h1, 16'h2222);
        step();
        check("full_still_not_ready", {31'd0, simd_ready}, 32'd0);
        simd_valid = 1'b0;
        mem_wb_in  = 34'd0;
        expect_wr(4'hA, 16'hA0A0);
        expect_wr(4'hB, 16'hA0A1);
        expect_wr(4'hC, 16'hA0A2);
        expect_wr(4'hD, 16'hA0A3);
        repeat (6) step();
        check("drained_ready", {31'd0, simd_ready}, 32'd1);

        // Reset mid-operation with three buffered entries
        mem_wb_in  = bus(1'b0, 1'b1, 4'h6, 16'h3333, 12'h000);
        simd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            simd_dest = 4'h8;
            simd_data = 16'h7000 + 16'(i);
            expect_wr(4'h6, 16'h3333);
            step();
        end
        check("pre_reset_we", {31'd0, rf_we}, 32'd1);
        @(negedge clock);
        #1;
        reset_n    = 1'b0;
        simd_valid = 1'b0;
        mem_wb_in  = 34'd0;
        #1;
        check("async_rst_we", {31'd0, rf_we}, 32'd0);
        check("async_rst_addr", {28'd0, rf_addr}, 32'd0);
        check("async_rst_wdata", {16'd0, rf_wdata}, 32'd0);
        check("async_rst_stall", {31'd0, stall_pipe}, 32'd0);
        check("async_rst_ready", {31'd0, simd_ready}, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (12) step();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
